// File: rtl/bilbo_pkg.sv
// Shared definitions for the BILBO BIST controller.
//   bist_state_t : controller FSM state encoding
//   MODE_*       : {B1,B2} BILBO mode codes
//   max3/cnt_width : helpers to size the single session counter
package bilbo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN_IN  = 3'd1,
    ST_RUN      = 3'd2,
    ST_SCAN_OUT = 3'd3,
    ST_COMPARE  = 3'd4,
    ST_DONE     = 3'd5
  } bist_state_t;

  localparam logic [1:0] MODE_NORMAL = 2'b11;
  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter only needs to reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_sig_shift.sv
// Signature capture register for the BILBO BIST controller.
// Shifts right, inserting the serial scan-out bit at the MSB, so after
// SIG_LEN captures the first captured bit sits in bit 0.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (register -> 0)
//   i_clr   : synchronous clear (priority over i_en)
//   i_en    : capture enable
//   i_so    : serial bit to capture
//   o_sig   : captured signature
module bist_sig_shift #(
  parameter int SIG_LEN = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_so,
  output logic [SIG_LEN-1:0] o_sig
);

  logic [SIG_LEN-1:0] r_sig;
  logic [SIG_LEN-1:0] w_sig_next;

  genvar gi;
  generate
    for (gi = 0; gi < SIG_LEN; gi++) begin : g_bit
      if (gi == SIG_LEN - 1) begin : g_msb
        assign w_sig_next[gi] = i_so;
      end else begin : g_lower
        assign w_sig_next[gi] = r_sig[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_sig_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/bilbo_bist_controller.sv
// BIST session controller sitting directly upstream of a BILBO system.
// Sequence: scan a seed in, run the PRPG/MISR, scan the signature out,
// compare against GOLDEN, then report Done/Pass.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_start  : begin a session (accepted in IDLE or DONE only)
//   i_abort  : cancel session, return to IDLE (priority over i_start)
//   i_so     : serial scan-out from the BILBO system
//   o_b1/o_b2: BILBO mode bits
//   o_si     : serial scan-in to the BILBO system
//   o_busy   : session in progress
//   o_done   : session finished (held until next Start or Abort)
//   o_pass   : signature matched GOLDEN (valid while o_done)
//   o_sig    : captured signature
module bilbo_bist_controller
  import bilbo_pkg::*;
#(
  parameter int                  SEED_LEN   = 13,
  parameter logic [SEED_LEN-1:0] SEED       = 13'b1000110000000,
  parameter int                  RUN_CYCLES = 4,
  parameter int                  SIG_LEN    = 5,
  parameter logic [SIG_LEN-1:0]  GOLDEN     = 5'b01011
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_so,
  output logic               o_b1,
  output logic               o_b2,
  output logic               o_si,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [SIG_LEN-1:0] o_sig
);

  localparam int CNT_MAX = max3(SEED_LEN, RUN_CYCLES, SIG_LEN);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(SEED_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIG_LAST  = CNT_W'(SIG_LEN - 1);

  bist_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_mode;
  logic               r_si;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_seed_next;
  logic               w_start_ok;
  logic               w_sig_en;
  logic [SIG_LEN-1:0] w_sig;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Si is registered, so the bit presented in the next SCAN_IN cycle is
  // selected with the incremented count.
  assign w_seed_next = |(SEED & (SEED_LEN'(1) << w_cnt_inc));

  assign w_start_ok = i_start && !i_abort &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sig_en   = (r_state == ST_SCAN_OUT) && !i_abort;

  bist_sig_shift #(
    .SIG_LEN (SIG_LEN)
  ) u_sig_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start_ok),
    .i_en    (w_sig_en),
    .i_so    (i_so),
    .o_sig   (w_sig)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_NORMAL;
      r_si    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_NORMAL;
      r_si    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state <= ST_SCAN_IN;
            r_cnt   <= '0;
            r_mode  <= MODE_SHIFT;
            r_si    <= SEED[0];
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        ST_SCAN_IN: begin
          if (r_cnt == SEED_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_mode  <= MODE_RUN;
            r_si    <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            r_si  <= w_seed_next;
          end
        end
        ST_RUN: begin
          if (r_cnt == RUN_LAST) begin
            r_state <= ST_SCAN_OUT;
            r_cnt   <= '0;
            r_mode  <= MODE_SHIFT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_SCAN_OUT: begin
          if (r_cnt == SIG_LAST) begin
            r_state <= ST_COMPARE;
            r_cnt   <= '0;
            r_mode  <= MODE_NORMAL;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_COMPARE: begin
          // Final capture landed on the previous edge, so w_sig is complete.
          r_pass  <= (w_sig == GOLDEN);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_mode  <= MODE_NORMAL;
          r_si    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign o_b1   = r_mode[1];
  assign o_b2   = r_mode[0];
  assign o_si   = r_si;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_pass = r_pass;
  assign o_sig  = w_sig;

endmodule
